// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
package pipeline_ctrl_pkg;

    localparam int REG_AW = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Operand bypass selection for the two ALU sources; the Memory stage wins over Writeback.
module fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wbs,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wbs,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b
);

    logic [1:0][REG_AW-1:0] src;
    logic [1:0][1:0]        sel;

    assign src = {ex_rs2, ex_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_op
            assign sel[gi] = (mem_wbs && (mem_rd == src[gi])) ? FWD_MEM :
                             (wb_wbs  && (wb_rd  == src[gi])) ? FWD_WB  : FWD_RF;
        end
    endgenerate

    assign fwd_a = sel[0];
    assign fwd_b = sel[1];

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stalls, flushes, bypass selection and halt for a 5-stage core.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wbs,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wbs,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wbs,
    input  logic              br_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    input  logic              halt_req,
    output logic              pc_en,
    output logic              fd_en,
    output logic              de_en,
    output logic              em_en,
    output logic              mw_en,
    output logic              fd_flush,
    output logic              de_flush,
    output logic              mw_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [15:0]       stall_cnt
);

    state_e      state_q, state_d;
    logic        redir_pend_q, redir_pend_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_stall;
    logic        load_use;
    fwd_sel_t    fwd_a_raw, fwd_b_raw;

    fwd_unit u_fwd (
        .ex_rs1  (ex_rs1),
        .ex_rs2  (ex_rs2),
        .mem_rd  (mem_rd),
        .mem_wbs (mem_wbs),
        .wb_rd   (wb_rd),
        .wb_wbs  (wb_wbs),
        .fwd_a   (fwd_a_raw),
        .fwd_b   (fwd_b_raw)
    );

    assign mem_stall = dmem_req & ~dmem_ready;
    assign load_use  = ex_load & ex_wbs &
                       ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));

    always_comb begin
        state_d      = state_q;
        redir_pend_d = redir_pend_q;
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        de_en        = 1'b1;
        em_en        = 1'b1;
        mw_en        = 1'b1;
        fd_flush     = 1'b0;
        de_flush     = 1'b0;
        mw_flush     = 1'b0;

        if (rst) begin
            {pc_en, fd_en, de_en, em_en, mw_en} = 5'b00000;
            {fd_flush, de_flush, mw_flush}      = 3'b111;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        {pc_en, fd_en, de_en, em_en} = 4'b0000;
                        mw_flush = 1'b1;
                        state_d  = ST_MEM_WAIT;
                    end else if (halt_req) begin
                        {pc_en, fd_en, de_en, em_en, mw_en} = 5'b00000;
                        state_d = ST_HALT;
                    end else if (br_taken) begin
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                        state_d  = ST_REDIRECT;
                    end else if (load_use) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_stall) begin
                        {pc_en, fd_en, de_en, em_en} = 4'b0000;
                        mw_flush = 1'b1;
                    end else begin
                        // Execute was frozen, so any branch there is handled next cycle in RUN.
                        fd_flush     = redir_pend_q;
                        redir_pend_d = 1'b0;
                        state_d      = ST_RUN;
                    end
                end
                ST_REDIRECT: begin
                    if (mem_stall) begin
                        {pc_en, fd_en, de_en, em_en} = 4'b0000;
                        mw_flush     = 1'b1;
                        redir_pend_d = 1'b1;
                        state_d      = ST_MEM_WAIT;
                    end else begin
                        fd_flush = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                ST_HALT: begin
                    {pc_en, fd_en, de_en, em_en, mw_en} = 5'b00000;
                end
                default: state_d = ST_RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            redir_pend_q <= 1'b0;
            stall_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign fwd_a     = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b     = rst ? FWD_RF : fwd_b_raw;
    assign halted    = (state_q == ST_HALT);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expectations queued per applied vector, compared on output.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use1, id_use2, ex_wbs, ex_load, mem_wbs, wb_wbs;
    logic       br_taken, dmem_req, dmem_ready, halt_req;
    logic       pc_en, fd_en, de_en, em_en, mw_en;
    logic       fd_flush, de_flush, mw_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       halted;
    logic [15:0] stall_cnt;

    // Control vector layout: {pc,fd,de,em,mw enables, fd,de,mw flushes}
    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_RST  = 8'b00000_111;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_BR   = 8'b11111_110;
    localparam logic [7:0] C_RD   = 8'b11111_100;
    localparam logic [7:0] C_MW   = 8'b00001_001;
    localparam logic [7:0] C_HALT = 8'b00000_000;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [3:0]  fwd;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = 16'd0;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wbs(ex_wbs), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_wbs(mem_wbs), .wb_rd(wb_rd), .wb_wbs(wb_wbs),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .mw_flush(mw_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use1, id_use2, ex_wbs, ex_load, mem_wbs, wb_wbs}   = '0;
        {br_taken, dmem_req, dmem_ready, halt_req}             = '0;
    endtask

    // Called at a negedge with inputs already driven; leaves the bench at the next negedge.
    task automatic step(input string tag, input logic [7:0] c, input logic [3:0] f,
                        input logic h, input bit counts);
        exp_t e;
        exp_t got;
        sb_q.push_back('{ctrl: c, fwd: f, halted: h, cnt: exp_cnt});
        #2;
        e   = sb_q.pop_front();
        got = '{ctrl: {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush},
                fwd: {fwd_a, fwd_b}, halted: halted, cnt: stall_cnt};
        chk({tag, ".ctrl"},   32'(got.ctrl),   32'(e.ctrl));
        chk({tag, ".fwd"},    32'(got.fwd),    32'(e.fwd));
        chk({tag, ".halted"}, 32'(got.halted), 32'(e.halted));
        chk({tag, ".cnt"},    32'(got.cnt),    32'(e.cnt));
        $display("vec %-14s ctrl=%b fwd=%b halted=%b cnt=%0d", tag, got.ctrl, got.fwd,
                 got.halted, got.cnt);
        if (rst) exp_cnt = 16'd0;
        else if (counts && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset", C_RST, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step("reset_state", C_RST, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        step("idle", C_RUN, 4'b0000, 1'b0, 1'b0);

        // Load-use hazards
        ex_load = 1; ex_wbs = 1; ex_rd = 3; id_use1 = 1; id_rs1 = 3;
        step("lu_rs1", C_LU, 4'b0000, 1'b0, 1'b1);
        clear_inputs();
        step("lu_after", C_RUN, 4'b0000, 1'b0, 1'b0);
        ex_load = 1; ex_wbs = 1; ex_rd = 9; id_use2 = 1; id_rs2 = 9; id_rs1 = 9;
        step("lu_rs2", C_LU, 4'b0000, 1'b0, 1'b1);
        id_rs2 = 4;
        step("lu_nomatch", C_RUN, 4'b0000, 1'b0, 1'b0);
        id_rs2 = 9; ex_wbs = 0;
        step("lu_nowbs", C_RUN, 4'b0000, 1'b0, 1'b0);
        ex_wbs = 1; br_taken = 1;
        step("lu_vs_branch", C_BR, 4'b0000, 1'b0, 1'b0);
        clear_inputs();
        step("lu_redirect", C_RD, 4'b0000, 1'b0, 1'b0);

        // Forwarding
        mem_rd = 5; wb_rd = 5; mem_wbs = 1; wb_wbs = 1; ex_rs1 = 5; ex_rs2 = 7;
        step("fwd_mem", C_RUN, 4'b0100, 1'b0, 1'b0);
        mem_wbs = 0;
        step("fwd_wb", C_RUN, 4'b1000, 1'b0, 1'b0);
        mem_wbs = 1; ex_rs2 = 5;
        step("fwd_both", C_RUN, 4'b0101, 1'b0, 1'b0);
        mem_wbs = 0; wb_wbs = 0;
        step("fwd_none", C_RUN, 4'b0000, 1'b0, 1'b0);
        mem_rd = 0; mem_wbs = 1; ex_rs1 = 0; ex_rs2 = 0; wb_rd = 0; wb_wbs = 1;
        step("fwd_reg0", C_RUN, 4'b0101, 1'b0, 1'b0);
        clear_inputs();

        // Branch
        br_taken = 1;
        step("br_c0", C_BR, 4'b0000, 1'b0, 1'b0);
        br_taken = 0;
        step("br_c1", C_RD, 4'b0000, 1'b0, 1'b0);
        step("br_c2", C_RUN, 4'b0000, 1'b0, 1'b0);

        // Memory wait with a branch held through it
        do_reset();
        dmem_req = 1; dmem_ready = 0; br_taken = 1;
        for (int i = 0; i < 3; i++) step("mem_wait", C_MW, 4'b0000, 1'b0, 1'b1);
        dmem_ready = 1;
        step("mem_exit", C_RUN, 4'b0000, 1'b0, 1'b0);
        dmem_req = 0; dmem_ready = 0;
        step("mem_br_c0", C_BR, 4'b0000, 1'b0, 1'b0);
        br_taken = 0;
        step("mem_br_c1", C_RD, 4'b0000, 1'b0, 1'b0);
        step("mem_br_c2", C_RUN, 4'b0000, 1'b0, 1'b0);

        // Memory stall arriving in REDIRECT defers the fetch flush
        br_taken = 1;
        step("rd_br", C_BR, 4'b0000, 1'b0, 1'b0);
        br_taken = 0; dmem_req = 1;
        step("rd_stall", C_MW, 4'b0000, 1'b0, 1'b1);
        step("rd_wait", C_MW, 4'b0000, 1'b0, 1'b1);
        dmem_ready = 1;
        step("rd_reissue", C_RD, 4'b0000, 1'b0, 1'b0);
        clear_inputs();
        step("rd_done", C_RUN, 4'b0000, 1'b0, 1'b0);

        // Reset aborting REDIRECT and a MEM_WAIT with a pending flush
        br_taken = 1;
        step("ab_br", C_BR, 4'b0000, 1'b0, 1'b0);
        br_taken = 0;
        do_reset();
        step("ab_rd_clean", C_RUN, 4'b0000, 1'b0, 1'b0);
        br_taken = 1;
        step("ab_br2", C_BR, 4'b0000, 1'b0, 1'b0);
        br_taken = 0; dmem_req = 1;
        step("ab_stall", C_MW, 4'b0000, 1'b0, 1'b1);
        do_reset();
        dmem_req = 0;
        step("ab_mw_clean", C_RUN, 4'b0000, 1'b0, 1'b0);

        // Halt: memory stall outranks it, then it sticks until reset
        dmem_req = 1; halt_req = 1;
        step("h_vs_mem", C_MW, 4'b0000, 1'b0, 1'b1);
        dmem_ready = 1;
        step("h_mem_exit", C_RUN, 4'b0000, 1'b0, 1'b0);
        dmem_req = 0; dmem_ready = 0; br_taken = 1;
        step("h_req", C_HALT, 4'b0000, 1'b0, 1'b1);
        halt_req = 0;
        for (int i = 0; i < 10; i++) begin
            br_taken = i[0];
            dmem_req = i[1];
            step("h_hold", C_HALT, 4'b0000, 1'b1, 1'b0);
        end
        clear_inputs();
        mem_rd = 5; mem_wbs = 1; ex_rs1 = 5;
        rst = 1'b1;
        step("h_rst", C_RST, 4'b0000, 1'b1, 1'b0);
        rst = 1'b0;
        step("h_after_rst", C_RUN, 4'b0100, 1'b0, 1'b0);
        clear_inputs();

        // Saturation of stall_cnt under a held load-use stall
        do_reset();
        ex_load = 1; ex_wbs = 1; ex_rd = 2; id_use1 = 1; id_rs1 = 2;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #2;
        chk("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
        for (int i = 0; i < 6; i++) @(posedge clk);
        #2;
        chk("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);
        chk("sat_pc_en", 32'(pc_en), 32'd0);
        $display("vec %-14s cnt=%0h after 65540 stall cycles", "saturate", stall_cnt);
        @(negedge clk);
        exp_cnt = 16'hFFFF;
        step("sat_hold", C_LU, 4'b0000, 1'b0, 1'b1);
        clear_inputs();
        step("sat_idle", C_RUN, 4'b0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
